// File: rtl/inst_rom_loader.sv
// inst_rom_loader: receives an instruction image as a byte stream
// (16-bit word count N, then N big-endian 32-bit words) and writes it into
// the instruction ROM write port. The CPU core is held in reset until the
// whole image has been written.
//
// Handshake: a byte moves on a rising clk edge where byte_valid_i and
// byte_ready_o are both 1. byte_ready_o depends only on the current state,
// never on byte_valid_i. The host may hold byte_valid_i low at any point,
// and the loader then waits with no timeout. load_req_i has priority over
// any byte offered in the same cycle, and that byte is dropped.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Capacity in words. It is held at 33 bits so that the comparison with
  // the 16-bit count stays exact for any practical ADDR_W.
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  state_t            state;
  logic [7:0]        cnt_hi;
  logic [15:0]       last_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       partial;
  logic              we_q;
  logic              take;
  logic [15:0]       count;
  logic              at_last;

  assign byte_ready_o = (state == CNT_HI) || (state == CNT_LO) || (state == DATA);
  assign take         = byte_valid_i && byte_ready_o;
  assign count        = {cnt_hi, byte_i};
  assign at_last      = (32'(word_idx) == 32'(last_idx));
  assign dbg_state    = state;

  // The strobe is registered. It is gated by a concurrent restart so that
  // a restart that lands on a WRITE cycle produces no write on that edge.
  assign mem_we_o = we_q && !load_req_i;

  // Loader FSM with registered write port and core-control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt_hi     <= '0;
      last_idx   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      we_q       <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else if (load_req_i) begin
      state     <= CNT_HI;
      word_idx  <= '0;
      byte_cnt  <= '0;
      partial   <= '0;
      we_q      <= 1'b0;
      cpu_rst_o <= 1'b1;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE: state <= CNT_HI;
        CNT_HI: begin
          if (take) begin
            cnt_hi <= byte_i;
            state  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (take) begin
            if (count == 16'd0) begin
              state     <= RUN;
              cpu_rst_o <= 1'b0;
              done_o    <= 1'b1;
            end else if ({17'd0, count} > CAP) begin
              state <= ERR;
              err_o <= 1'b1;
            end else begin
              last_idx <= count - 16'd1;
              word_idx <= '0;
              byte_cnt <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (take) begin
            partial  <= {partial[15:0], byte_i};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              we_q       <= 1'b1;
              mem_addr_o <= word_idx;
              mem_data_o <= {partial, byte_i};
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          // The index is not advanced past the last word. A full-capacity
          // image therefore never wraps the index back to 0.
          if (at_last) begin
            state     <= RUN;
            cpu_rst_o <= 1'b0;
            done_o    <= 1'b1;
          end else begin
            word_idx <= word_idx + ADDR_W'(1);
            state    <= DATA;
          end
        end
        RUN, ERR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: drives byte streams into two loader instances
// (ADDR_W=10 and ADDR_W=2). The written words and their timing are compared
// with an image model that decodes the stream format directly.
module tb_inst_rom_loader;

  localparam int AW_A = 10;
  localparam int AW_B = 2;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       load_req   [2];
  logic       byte_valid [2];
  logic [7:0] byte_in    [2];

  logic            ready_a, we_a, cpu_rst_a, done_a, err_a;
  logic [AW_A-1:0] addr_a;
  logic [31:0]     data_a;
  logic [2:0]      dbg_a;
  logic            ready_b, we_b, cpu_rst_b, done_b, err_b;
  logic [AW_B-1:0] addr_b;
  logic [31:0]     data_b;
  logic [2:0]      dbg_b;

  inst_rom_loader #(.ADDR_W(AW_A)) dut_a (
    .clk(clk), .rst(rst), .load_req_i(load_req[0]), .byte_i(byte_in[0]),
    .byte_valid_i(byte_valid[0]), .byte_ready_o(ready_a), .mem_we_o(we_a),
    .mem_addr_o(addr_a), .mem_data_o(data_a), .cpu_rst_o(cpu_rst_a),
    .done_o(done_a), .err_o(err_a), .dbg_state(dbg_a)
  );

  inst_rom_loader #(.ADDR_W(AW_B)) dut_b (
    .clk(clk), .rst(rst), .load_req_i(load_req[1]), .byte_i(byte_in[1]),
    .byte_valid_i(byte_valid[1]), .byte_ready_o(ready_b), .mem_we_o(we_b),
    .mem_addr_o(addr_b), .mem_data_o(data_b), .cpu_rst_o(cpu_rst_b),
    .done_o(done_b), .err_o(err_b), .dbg_state(dbg_b)
  );

  // Uniform view of both instances, indexed by sel.
  logic       v_ready[2], v_we[2], v_cpu_rst[2], v_done[2], v_err[2];
  logic [9:0] v_addr[2];
  logic [31:0] v_data[2];
  always_comb begin
    v_ready[0] = ready_a;  v_we[0] = we_a;  v_cpu_rst[0] = cpu_rst_a;
    v_done[0]  = done_a;   v_err[0] = err_a; v_addr[0] = addr_a; v_data[0] = data_a;
    v_ready[1] = ready_b;  v_we[1] = we_b;  v_cpu_rst[1] = cpu_rst_b;
    v_done[1]  = done_b;   v_err[1] = err_b; v_addr[1] = {8'd0, addr_b}; v_data[1] = data_b;
  end

  int          sel = 0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cyc;
  logic        prev_done = 1'b0;
  int          ready_in_write;
  int          model_status;
  int          hs_cyc[$];
  wr_t         wr_q[$];
  logic [41:0] exp_q[$];
  logic [7:0]  stream[$];

  // Write log for the selected instance, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t w;
    cyc = cyc + 1;
    if (v_we[sel]) begin
      w.addr = v_addr[sel];
      w.data = v_data[sel];
      w.cyc  = cyc;
      wr_q.push_back(w);
      if (v_ready[sel]) ready_in_write++;
    end
    if (v_done[sel] && !prev_done && done_cyc < 0) done_cyc = cyc;
    prev_done = v_done[sel];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Decodes stream[] into the image writes it describes, given a capacity.
  // model_status: 0 = image incomplete, 1 = running, 2 = too large.
  task automatic build_expect(input int cap);
    int n;
    exp_q.delete();
    model_status = 0;
    if (stream.size() < 2) return;
    n = {stream[0], stream[1]};
    if (n == 0) begin model_status = 1; return; end
    if (n > cap) begin model_status = 2; return; end
    for (int i = 0; i < n; i++) begin
      if (5 + 4 * i >= stream.size()) return;
      exp_q.push_back({10'(i), stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
    end
    model_status = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    @(negedge clk);
    byte_in[sel]    = b;
    byte_valid[sel] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (v_ready[sel]) begin ok = 1'b1; hs_cyc.push_back(cyc); end
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake: byte %02h ready=%0b, required accepted within 100 cycles", b, v_ready[sel]);
    end
  endtask

  task automatic send_stream(input int gap_at, input int gap_len);
    wr_q.delete();
    hs_cyc.delete();
    done_cyc = -1;
    ready_in_write = 0;
    prev_done = v_done[sel];
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i]);
      if (i == gap_at && gap_len > 0) begin
        @(negedge clk);
        byte_valid[sel] = 1'b0;
        repeat (gap_len - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    byte_valid[sel] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req[sel] = 1'b1;
    @(negedge clk);
    load_req[sel] = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load_req[k] = 1'b0; byte_valid[k] = 1'b0; byte_in[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({v_ready[k], v_we[k], v_cpu_rst[k], v_done[k], v_err[k]} !== 5'b00100) begin
        errors++;
        $display("FAIL reset_flags[%0d]: ready,we,cpu_rst,done,err=%b required 00100", k,
                 {v_ready[k], v_we[k], v_cpu_rst[k], v_done[k], v_err[k]});
      end
      checks++;
      if ({v_addr[k], v_data[k]} !== 42'd0) begin
        errors++;
        $display("FAIL reset_mem_port[%0d]: addr=%h data=%h required 0", k, v_addr[k], v_data[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (v_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready[%0d]: ready=%b required 1", k, v_ready[k]);
      end
    end
  endtask

  task automatic test_basic();
    sel = 0;
    stream = {8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};
    build_expect(1 << AW_A);
    send_stream(-1, 0);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if ({wr_q[i].addr, wr_q[i].data} !== exp_q[i] || wr_q[i].cyc != hs_cyc[5+4*i] + 1) begin
        errors++;
        $display("FAIL basic_write[%0d]: got %h @%0d required %h @%0d", i,
                 {wr_q[i].addr, wr_q[i].data}, wr_q[i].cyc, exp_q[i], hs_cyc[5+4*i] + 1);
      end
    end
    checks++;
    if (wr_q.size() > 0 && done_cyc != wr_q[wr_q.size()-1].cyc + 1) begin
      errors++;
      $display("FAIL basic_done_timing: done rose @%0d required @%0d", done_cyc, wr_q[wr_q.size()-1].cyc + 1);
    end
    checks++;
    if ({v_cpu_rst[0], v_done[0], v_err[0]} !== 3'b010 || ready_in_write != 0) begin
      errors++;
      $display("FAIL basic_status: cpu_rst,done,err=%b ready_in_write=%0d required 010 and 0",
               {v_cpu_rst[0], v_done[0], v_err[0]}, ready_in_write);
    end
    checks++;
    if ({v_addr[0], v_data[0]} !== {10'd1, 32'h34020002}) begin
      errors++;
      $display("FAIL basic_hold: addr=%h data=%h required 001 34020002", v_addr[0], v_data[0]);
    end
  endtask

  task automatic test_zero_and_restart_run();
    int acc = 0;
    sel = 0;
    pulse_load();
    checks++;
    if ({v_cpu_rst[0], v_done[0]} !== 2'b10) begin
      errors++;
      $display("FAIL restart_from_run: cpu_rst,done=%b required 10", {v_cpu_rst[0], v_done[0]});
    end
    stream = {8'h00, 8'h00};
    build_expect(1 << AW_A);
    send_stream(-1, 0);
    checks++;
    if (wr_q.size() != 0 || model_status != 1 || v_done[0] !== 1'b1 || done_cyc != hs_cyc[1] + 1) begin
      errors++;
      $display("FAIL zero_count: writes=%0d done=%b rose @%0d required 0 writes, done=1 @%0d",
               wr_q.size(), v_done[0], done_cyc, hs_cyc[1] + 1);
    end
    @(negedge clk);
    byte_in[0] = 8'h55;
    byte_valid[0] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      if (v_ready[0]) acc++;
      @(negedge clk);
    end
    byte_valid[0] = 1'b0;
    checks++;
    if (acc != 0) begin
      errors++;
      $display("FAIL run_ignores_bytes: ready high %0d cycles required 0", acc);
    end
  endtask

  task automatic test_err();
    sel = 1;
    stream = {8'h00, 8'h05};
    build_expect(1 << AW_B);
    send_stream(-1, 0);
    checks++;
    if (model_status != 2 || {v_err[1], v_cpu_rst[1], v_done[1], v_ready[1]} !== 4'b1100 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL err_oversize: err,cpu_rst,done,ready=%b writes=%0d required 1100 and 0",
               {v_err[1], v_cpu_rst[1], v_done[1], v_ready[1]}, wr_q.size());
    end
    pulse_load();
    checks++;
    if ({v_err[1], v_cpu_rst[1], v_ready[1]} !== 3'b011) begin
      errors++;
      $display("FAIL err_restart: err,cpu_rst,ready=%b required 011", {v_err[1], v_cpu_rst[1], v_ready[1]});
    end
  endtask

  // Loads a random image into the selected instance and checks every write.
  task automatic test_image(input string name, input int n, input int cap,
                            input int gap_at, input int gap_len);
    stream = {8'(n >> 8), 8'(n)};
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 255)));
    build_expect(cap);
    send_stream(gap_at, gap_len);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if ({wr_q[i].addr, wr_q[i].data} !== exp_q[i] || wr_q[i].cyc != hs_cyc[5+4*i] + 1) begin
        errors++;
        $display("FAIL %s_write[%0d]: got %h @%0d required %h @%0d", name, i,
                 {wr_q[i].addr, wr_q[i].data}, wr_q[i].cyc, exp_q[i], hs_cyc[5+4*i] + 1);
      end
    end
    checks++;
    if (v_done[sel] !== 1'b1 || v_cpu_rst[sel] !== 1'b0 || ready_in_write != 0 ||
        (wr_q.size() > 0 && done_cyc != wr_q[wr_q.size()-1].cyc + 1)) begin
      errors++;
      $display("FAIL %s_done: done=%b cpu_rst=%b ready_in_write=%0d rose @%0d required 1,0,0 after last write",
               name, v_done[sel], v_cpu_rst[sel], ready_in_write, done_cyc);
    end
  endtask

  task automatic test_full_capacity();
    sel = 1;
    pulse_load();
    test_image("full_cap", 1 << AW_B, 1 << AW_B, -1, 0);
    checks++;
    if (v_addr[1] !== 10'd3) begin
      errors++;
      $display("FAIL full_cap_last_addr: addr=%h required 003", v_addr[1]);
    end
  endtask

  task automatic test_gap();
    sel = 0;
    pulse_load();
    test_image("gap", 1, 1 << AW_A, 3, 7);
  endtask

  task automatic test_restart_midword();
    sel = 0;
    pulse_load();
    stream = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(-1, 0);
    @(negedge clk);
    load_req[0] = 1'b1;
    byte_in[0] = 8'hEE;
    byte_valid[0] = 1'b1;
    #1;
    checks++;
    if (v_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midword_ready: ready=%b required 1 with partial word pending", v_ready[0]);
    end
    @(negedge clk);
    load_req[0] = 1'b0;
    byte_valid[0] = 1'b0;
    #1;
    checks++;
    if ({v_cpu_rst[0], v_done[0], v_ready[0]} !== 3'b101) begin
      errors++;
      $display("FAIL midword_restart: cpu_rst,done,ready=%b required 101", {v_cpu_rst[0], v_done[0], v_ready[0]});
    end
    stream = {8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_stream(-1, 0);
    checks++;
    if (wr_q.size() != 1 || {wr_q[0].addr, wr_q[0].data} !== {10'd0, 32'hA1B2C3D4} || v_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL midword_reload: writes=%0d first=%h done=%b required 1 write 000a1b2c3d4 done=1",
               wr_q.size(), (wr_q.size() > 0) ? {wr_q[0].addr, wr_q[0].data} : 42'd0, v_done[0]);
    end
  endtask

  task automatic test_random();
    sel = 0;
    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(1, 6);
      pulse_load();
      test_image("random", n, 1 << AW_A, $urandom_range(0, 4 * n + 1), $urandom_range(0, 3));
    end
  endtask

  task automatic test_async_reset();
    sel = 0;
    pulse_load();
    stream = {8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send_stream(-1, 0);
    checks++;
    if (v_data[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL async_pre: data=%h required deadbeef", v_data[0]);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({v_ready[0], v_cpu_rst[0], v_done[0]} !== 3'b010 || {v_addr[0], v_data[0]} !== 42'd0) begin
      errors++;
      $display("FAIL async_reset: ready,cpu_rst,done=%b addr=%h data=%h required 010 and zeros",
               {v_ready[0], v_cpu_rst[0], v_done[0]}, v_addr[0], v_data[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (v_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_release: ready=%b required 1", v_ready[0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_and_restart_run();
    test_err();
    test_full_capacity();
    test_gap();
    test_restart_midword();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Hardware counterpart of the bench-side instruction preload in the min SOPC.
- Accepts a byte stream from a host link and writes big-endian 32-bit words into the instruction ROM's write port.
- Holds the CPU core in reset while loading and releases it when the image is complete.
- Sits between the host byte source, inst_rom and the openmips core reset input.

Parameters:
- ADDR_W, 10: word-address width of the instruction memory. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load_req_i  in  1  single-cycle pulse that restarts the load from any state.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader accepts byte_i this cycle.
- mem_we_o  out  1  write strobe to the instruction ROM.
- mem_addr_o  out  ADDR_W  word address.
- mem_data_o  out  32  word to write.
- cpu_rst_o  out  1  core reset, active-high, matching the core's RstEnable.
- done_o  out  1  image loaded; CPU running.
- err_o  out  1  image length exceeds capacity.

Behaviour:
- Reset values while rst=0:
  - state=IDLE.
  - byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0.
  - cpu_rst_o=1, done_o=0, err_o=0.
- Stream format:
  - 2-byte word count N, MSB first.
  - Then N words, 4 bytes each, MSB first. The word index is the address, starting at 0.
- Byte transfer occurs on a rising edge with byte_valid_i=1 and byte_ready_o=1.
- byte_ready_o is decoded from state: 1 in CNT_HI, CNT_LO and DATA only.
- FSM:
  - IDLE -> CNT_HI unconditionally, on the first clock after reset release.
  - CNT_HI: capture N[15:8] -> CNT_LO.
  - CNT_LO: capture N[7:0].
    - If N=0 -> RUN.
    - If N > 2^ADDR_W -> ERR.
    - Otherwise clear the word index and byte counter -> DATA.
  - DATA: shift byte into the assembly register (first byte lands in [31:24]); increment the byte counter (2 bits).
    - On the 4th byte -> WRITE.
  - WRITE: one cycle.
    - mem_we_o=1, mem_addr_o=word index, mem_data_o=assembled word. byte_ready_o=0.
    - Then increment the word index.
    - If the written word was index N-1 -> RUN; otherwise -> DATA.
  - RUN: cpu_rst_o=0, done_o=1. byte_ready_o=0. Extra bytes are not consumed.
  - ERR: err_o=1, cpu_rst_o=1, byte_ready_o=0. Holds until load_req_i.
- Output timing:
  - mem_we_o is high for exactly one cycle per word.
  - Per-word latency: the strobe is asserted the cycle after the 4th byte handshake.
  - Minimum cost is 5 cycles per word.
- cpu_rst_o falls on the same edge that enters RUN, i.e. the cycle after the last mem_we_o.
- mem_addr_o and mem_data_o hold their last values outside WRITE.
- load_req_i has priority over every transition, including a concurrent byte handshake; the concurrent byte is dropped. On the next edge:
  - state=CNT_HI.
  - cpu_rst_o=1, done_o=0, err_o=0.
  - Byte counter and word index cleared; partial word discarded.
  - No write occurs that edge, even if the current state is WRITE.
- Boundaries:
  - N = 2^ADDR_W is legal; the last address is all-ones and the word index does not wrap before RUN.
  - N = 2^ADDR_W + 1 -> ERR.
  - byte_valid_i low mid-word stalls indefinitely with no timeout; the state and partial word are kept.
- Asynchronous reset mid-load forces IDLE immediately. The memory contents already written are not cleared.

Test Plan:
- Reset then stream 00 02 | 34 01 00 01 | 34 02 00 02:
  - Writes addr 0 = 0x34010001, then addr 1 = 0x34020002, one strobe each.
  - cpu_rst_o falls and done_o rises the cycle after the second strobe.
  - byte_ready_o=0 during each WRITE.
- Stream 00 00:
  - No mem_we_o; RUN one cycle after the count LSB.
  - Further bytes are not accepted (byte_ready_o=0).
- ADDR_W=2, stream count 00 05:
  - err_o=1, cpu_rst_o stays 1, no writes.
  - A load_req_i pulse then returns to CNT_HI with err_o=0.
- ADDR_W=2, N=4, full stream:
  - Addresses 0,1,2,3 written; done_o=1; no write to address 0 again.
- Valid gaps: deassert byte_valid_i for 7 cycles after byte 2 of word 0 -> assembled word still exact, single strobe.
- Restart: load_req_i during RUN, and separately mid-word coinciding with a byte handshake:
  - cpu_rst_o=1 and done_o=0 next cycle.
  - The next stream loads from address 0.
  - Discarded bytes never appear in mem_data_o.
